divu64_seq: RTL and testbench

Sequential 64-bit unsigned restoring divider for the factorial computation system. It is the inverse datapath to the Booth multiplier step. It retires one quotient bit per clock, and its subtractor is the shared 64-bit carry-lookahead adder. The factorial controller uses it to check and normalise results, for example n!/(n-1)! = n. It also serves as the system's division unit, behind the same op_start/op_clear/op_done handshake as the multiplier.

---
 rtl/divu64_pkg.sv | 14 +
 rtl/cla64.sv | 47 ++++
 rtl/divu64_seq.sv | 143 ++++++++++++++
 tb/tb_divu64_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/divu64_pkg.sv
// Shared constants for the 64-bit sequential restoring divider.
package divu64_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned DIV_STEPS = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DATA_W-1:0] ALL_ONES_64 = {DATA_W{1'b1}};

endpackage

// File: rtl/cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups with a group-level carry chain.
module cla64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        ci,
    output logic [63:0] s,
    output logic        co
);

    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;
    logic [15:0] gg;
    logic [15:0] gp;
    logic [16:0] gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = ci;
        // Group generate/propagate, then carry across groups
        for (int k = 0; k < 16; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        // Bit carries inside each group from that group's carry-in
        for (int k = 0; k < 16; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[64] = gc[16];
        s     = p ^ c[63:0];
        co    = c[64];
    end

endmodule

// File: rtl/divu64_seq.sv
// Sequential 64-bit unsigned restoring divider, one quotient bit per clock,
// behind the op_start/op_clear/op_done handshake.
module divu64_seq
    import divu64_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              op_done,
    output logic              div_by_zero
);

    logic [1:0]        state, state_nxt;
    // Top bit of the partial remainder is always zero after a step, so only 64 bits are kept
    logic [DATA_W-1:0] r, r_nxt;
    logic [DATA_W-1:0] q, q_nxt;
    logic [DATA_W-1:0] d, d_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] quotient_nxt, remainder_nxt;
    logic              op_done_nxt, div_by_zero_nxt;

    logic [DATA_W:0]   t;
    logic [DATA_W-1:0] diff;
    logic              co;
    logic              non_neg;
    logic [DATA_W-1:0] r_step;
    logic [DATA_W-1:0] q_step;

    assign t = {r, q[DATA_W-1]};

    cla64 u_sub (
        .a  (t[DATA_W-1:0]),
        .b  (~d),
        .ci (1'b1),
        .s  (diff),
        .co (co)
    );

    // Step datapath and next-state
    always_comb begin
        non_neg = t[DATA_W] | co;
        r_step  = non_neg ? diff : t[DATA_W-1:0];
        q_step  = {q[DATA_W-2:0], non_neg};

        state_nxt       = state;
        r_nxt           = r;
        q_nxt           = q;
        d_nxt           = d;
        cnt_nxt         = cnt;
        quotient_nxt    = quotient;
        remainder_nxt   = remainder;
        op_done_nxt     = op_done;
        div_by_zero_nxt = div_by_zero;

        if (op_clear) begin
            state_nxt       = IDLE;
            r_nxt           = '0;
            q_nxt           = '0;
            d_nxt           = '0;
            cnt_nxt         = '0;
            quotient_nxt    = '0;
            remainder_nxt   = '0;
            op_done_nxt     = 1'b0;
            div_by_zero_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (op_start) begin
                        r_nxt   = '0;
                        cnt_nxt = '0;
                        if (divisor == '0) begin
                            state_nxt       = DONE;
                            q_nxt           = '0;
                            d_nxt           = '0;
                            quotient_nxt    = ALL_ONES_64;
                            remainder_nxt   = dividend;
                            op_done_nxt     = 1'b1;
                            div_by_zero_nxt = 1'b1;
                        end else begin
                            state_nxt       = BUSY;
                            q_nxt           = dividend;
                            d_nxt           = divisor;
                            quotient_nxt    = '0;
                            remainder_nxt   = '0;
                            op_done_nxt     = 1'b0;
                            div_by_zero_nxt = 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_nxt   = r_step;
                    q_nxt   = q_step;
                    cnt_nxt = CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_W'(DIV_STEPS - 1)) begin
                        state_nxt       = DONE;
                        quotient_nxt    = q_step;
                        remainder_nxt   = r_step;
                        op_done_nxt     = 1'b1;
                        div_by_zero_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt       = IDLE;
                    quotient_nxt    = '0;
                    remainder_nxt   = '0;
                    op_done_nxt     = 1'b0;
                    div_by_zero_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            r           <= r_nxt;
            q           <= q_nxt;
            d           <= d_nxt;
            cnt         <= cnt_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            op_done     <= op_done_nxt;
            div_by_zero <= div_by_zero_nxt;
        end
    end

endmodule

// File: tb/tb_divu64_seq.sv
// Directed self-checking bench for divu64_seq.
module tb_divu64_seq;

    logic        clk;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        op_done;
    logic        div_by_zero;

    int n_checks;
    int n_fail;
    int lat;
    int rises;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    divu64_seq dut (
        .clk         (clk),
        .reset       (reset),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .op_done     (op_done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_q"},    quotient, 64'd0);
        check({tag, "_r"},    remainder, 64'd0);
        check({tag, "_done"}, 64'(op_done), 64'd0);
        check({tag, "_dbz"},  64'(div_by_zero), 64'd0);
    endtask

    // Drive operands and pulse op_start across one rising edge (E0)
    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    // Count rising edges until op_done, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (!op_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] eq, input logic [63:0] er);
        start_op(a, b);
        check({tag, "_busy_done"}, 64'(op_done), 64'd0);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'd64);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_check("d100_7", 64'd100, 64'd7, 64'd14, 64'd2);
        // DONE holds its result
        repeat (5) @(posedge clk);
        #1;
        check("hold_q", quotient, 64'd14);
        check("hold_done", 64'(op_done), 64'd1);

        run_check("fact20_19", 64'd2432902008176640000, 64'd121645100408832000, 64'd20, 64'd0);

        // Divide by zero completes on the capture edge
        start_op(64'd5, 64'd0);
        check("dz_done", 64'(op_done), 64'd1);
        check("dz_flag", 64'(div_by_zero), 64'd1);
        check("dz_q", quotient, ONES);
        check("dz_r", remainder, 64'd5);

        do_clear();
        check_idle_outputs("clear_done");

        run_check("max_div1", ONES, 64'd1, ONES, 64'd0);
        run_check("d3_max", 64'd3, ONES, 64'd0, 64'd3);
        do_clear();

        // Abort at E30
        start_op(64'd100, 64'd7);
        repeat (29) @(posedge clk);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        check_idle_outputs("abort");
        rises = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (op_done) rises++;
        end
        check("abort_no_done", 64'(rises), 64'd0);

        // op_start with new operands during BUSY is ignored
        start_op(64'd100, 64'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd33;
        op_start = 1'b1;
        repeat (3) @(negedge clk);
        op_start = 1'b0;
        wait_done(lat);
        check("ign_start_done", 64'(op_done), 64'd1);
        check("ign_start_q", quotient, 64'd14);
        check("ign_start_r", remainder, 64'd2);

        // Asynchronous reset in DONE clears outputs without a clock edge
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("areset_done");
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset mid-BUSY discards the in-flight result
        start_op(64'd100, 64'd7);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("areset_busy");
        @(negedge clk);
        reset = 1'b0;
        rises = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (op_done) rises++;
        end
        check("areset_no_done", 64'(rises), 64'd0);

        run_check("d1000_33", 64'd1000, 64'd33, 64'd30, 64'd10);

        // Restart straight from DONE clears outputs on the start edge
        start_op(64'd20, 64'd6);
        check("restart_clears_done", 64'(op_done), 64'd0);
        check("restart_clears_q", quotient, 64'd0);
        wait_done(lat);
        check("restart_latency", 64'(lat), 64'd64);
        check("restart_q", quotient, 64'd3);
        check("restart_r", remainder, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
